// File: rtl/dmux_stream_pkg.sv
// ============================================================================
// Module : dmux_stream_pkg
// Brief  : Steering-mode encodings and target decode for the dmux stream router.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package dmux_stream_pkg;

    typedef enum logic [1:0] {
        MODE_SEL = 2'b00,
        MODE_ALT = 2'b01,
        MODE_Y0  = 2'b10,
        MODE_Y1  = 2'b11
    } mode_e;

    // Returns the output index (0 or 1) a word is steered to.
    function automatic logic route_target(input logic [1:0] mode,
                                          input logic       sel,
                                          input logic       toggle);
        logic t;
        t = 1'b0;
        case (mode)
            MODE_SEL: t = sel;
            MODE_ALT: t = toggle;
            MODE_Y0:  t = 1'b0;
            default:  t = 1'b1;
        endcase
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmux_stream_slot.sv
// ============================================================================
// Module : dmux_slot
// Brief  : One-entry output holding register with valid/ready and handshake counter.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dmux_slot #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [WIDTH-1:0] data_q,  data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             drain;

    assign drain = valid_q & ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, drain};
        if (drain) begin
            valid_d = 1'b0;
        end
        // A load in the drain cycle keeps the slot full for back-to-back flow.
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign cnt_o   = cnt_q;

endmodule

`default_nettype wire

// File: rtl/dmux_stream.sv
// ============================================================================
// Module : dmux_stream
// Brief  : Registered 1:2 valid/ready stream router with per-output counters.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dmux_stream
    import dmux_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic             sel,
    input  logic             a_valid,
    output logic             a_ready,
    output logic [WIDTH-1:0] y0,
    output logic             y0_valid,
    input  logic             y0_ready,
    output logic [WIDTH-1:0] y1,
    output logic             y1_valid,
    input  logic             y1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic toggle_q, toggle_d;
    logic target;
    logic accept;

    assign target = route_target(mode, sel, toggle_q);

    // Head-of-line blocking: only the target slot's state gates the input.
    assign a_ready = target ? (~y1_valid | y1_ready) : (~y0_valid | y0_ready);
    assign accept  = a_valid & a_ready;

    always_comb begin
        toggle_d = toggle_q;
        if (accept && (mode == MODE_ALT)) begin
            toggle_d = ~toggle_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    dmux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (accept & ~target),
        .data_i  (a),
        .ready_i (y0_ready),
        .data_o  (y0),
        .valid_o (y0_valid),
        .cnt_o   (cnt0)
    );

    dmux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (accept & target),
        .data_i  (a),
        .ready_i (y1_ready),
        .data_o  (y1),
        .valid_o (y1_valid),
        .cnt_o   (cnt1)
    );

endmodule

`default_nettype wire

// File: tb/tb_dmux_stream.sv
// ============================================================================
// Module : tb_dmux_stream
// Brief  : Scoreboard bench for dmux_stream: random and directed traffic.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmux_stream;
    import dmux_stream_pkg::*;

    localparam int W  = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic [W-1:0]  a;
    logic          sel;
    logic          a_valid;
    logic          a_ready;
    logic [W-1:0]  y0, y1;
    logic          y0_valid, y1_valid;
    logic          y0_ready, y1_ready;
    logic [CW-1:0] cnt0, cnt1;

    dmux_stream #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .a        (a),
        .sel      (sel),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .y0       (y0),
        .y0_valid (y0_valid),
        .y0_ready (y0_ready),
        .y1       (y1),
        .y1_valid (y1_valid),
        .y1_ready (y1_ready),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    always #5 clk = ~clk;

    // Reference model state: words in flight per output, alternate parity, counts.
    logic [W-1:0]  q0[$];
    logic [W-1:0]  q1[$];
    bit            alt;
    logic [CW-1:0] mcnt0, mcnt1;
    int            checks   = 0;
    int            failures = 0;
    bit            acc;

    function automatic bit model_target();
        case (mode)
            MODE_SEL: return sel;
            MODE_ALT: return alt;
            MODE_Y0:  return 1'b0;
            default:  return 1'b1;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every cycle on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_y0_valid", y0_valid, 0);
            chk("rst_y1_valid", y1_valid, 0);
            chk("rst_cnt0", cnt0, 0);
            chk("rst_cnt1", cnt1, 0);
            chk("rst_a_ready", a_ready, 1);
            q0.delete();
            q1.delete();
            mcnt0 = '0;
            mcnt1 = '0;
        end else begin
            if (model_target())
                chk("a_ready", a_ready, (q1.size() == 0) || y1_ready);
            else
                chk("a_ready", a_ready, (q0.size() == 0) || y0_ready);
            chk("y0_valid", y0_valid, q0.size() != 0);
            chk("y1_valid", y1_valid, q1.size() != 0);
            chk("cnt0", cnt0, mcnt0);
            chk("cnt1", cnt1, mcnt1);
            if (q0.size() != 0 && y0_ready) begin
                chk("y0_data", y0, q0.pop_front());
                mcnt0 = mcnt0 + 1'b1;
            end
            if (q1.size() != 0 && y1_ready) begin
                chk("y1_data", y1, q1.pop_front());
                mcnt1 = mcnt1 + 1'b1;
            end
        end
    end

    // One cycle of stimulus; expected words are pushed at the accepting edge.
    task automatic cyc(input bit v, input logic [W-1:0] d, input bit s,
                       input logic [1:0] m, input bit r0, input bit r1);
        bit t;
        a_valid  = v;
        a        = d;
        sel      = s;
        mode     = m;
        y0_ready = r0;
        y1_ready = r1;
        @(negedge clk);
        acc = a_valid & a_ready;
        t   = model_target();
        @(posedge clk);
        if (acc) begin
            if (t) q1.push_back(a);
            else   q0.push_back(a);
            if (mode == MODE_ALT) alt = ~alt;
        end
        #1;
    endtask

    task automatic pulse_reset();
        a_valid = 1'b0;
        #2 rst_n = 1'b0;
        alt = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; a_valid = 1'b0; a = '0; sel = 1'b0; mode = MODE_SEL;
        y0_ready = 1'b0; y1_ready = 1'b0; alt = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Select routing
        cyc(1, 8'hA5, 0, MODE_SEL, 1, 1);
        cyc(1, 8'h3C, 1, MODE_SEL, 1, 1);
        repeat (2) cyc(0, 8'h00, 0, MODE_SEL, 1, 1);

        // Alternate routing, back to back
        cyc(1, 8'h11, 0, MODE_ALT, 1, 1);
        cyc(1, 8'h22, 0, MODE_ALT, 1, 1);
        cyc(1, 8'h33, 0, MODE_ALT, 1, 1);
        cyc(1, 8'h44, 0, MODE_ALT, 1, 1);
        repeat (2) cyc(0, 8'h00, 0, MODE_ALT, 1, 1);

        // Forced y0 with stalled sink, then simultaneous drain and load
        cyc(1, 8'h55, 0, MODE_Y0, 0, 1);
        repeat (3) cyc(1, 8'h66, 0, MODE_Y0, 0, 1);
        cyc(1, 8'h66, 0, MODE_Y0, 1, 1);
        repeat (2) cyc(0, 8'h00, 0, MODE_Y0, 1, 1);

        // Head-of-line blocking behind a stalled y1
        cyc(1, 8'h77, 1, MODE_SEL, 1, 0);
        repeat (3) cyc(1, 8'h88, 1, MODE_SEL, 1, 0);
        cyc(1, 8'h88, 1, MODE_SEL, 1, 1);
        repeat (2) cyc(0, 8'h00, 0, MODE_SEL, 1, 1);

        // Counter wrap on y0, then reset with words held
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'hC0 + i), 0, MODE_Y0, 1, 1);
        cyc(1, 8'hD1, 0, MODE_Y0, 0, 0);
        cyc(1, 8'hD2, 1, MODE_Y1, 0, 0);
        pulse_reset();
        repeat (2) cyc(0, 8'h00, 0, MODE_SEL, 1, 1);

        // Randomized traffic honouring the upstream hold rule
        for (int i = 0; i < 1500; i++) begin
            if (a_valid && !acc) begin
                cyc(1, a, sel, mode, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
            end else begin
                cyc(($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
                    2'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
            end
            if (i == 700) pulse_reset();
        end

        repeat (4) cyc(0, 8'h00, 0, MODE_SEL, 1, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
